// File: rtl/aes_pkg.sv
// +----------------------------------------------------------------------------+
// | aes_pkg : shared AES inverse-cipher constants, state encoding and helpers   |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

package aes_pkg;

  localparam int NR = 10;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ROUND = 2'd1;
  localparam state_t ST_FINAL = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Column-major byte order: byte (row, col) sits at bits [127-8*(4*col+row) -: 8].
  function automatic logic [7:0] get_byte(input logic [127:0] s, input int row, input int col);
    return s[127 - 8*(4*col + row) -: 8];
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        r[127 - 8*(4*c + rw) -: 8] = get_byte(s, rw, (c - rw + 4) % 4);
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_inv_mix_columns.sv
// +----------------------------------------------------------------------------+
// | aes_inv_mix_columns : combinational AES InvMixColumns over a 128-bit state  |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module aes_inv_mix_columns (
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Matrix rows {0e,0b,0d,09} rotated per output byte, built from shared xtime chains.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a  [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31 - 8*i -: 8];
      m2[i] = xt(a[i]);
      m4[i] = xt(m2[i]);
      m8[i] = xt(m4[i]);
      m9[i] = m8[i] ^ a[i];
      mb[i] = m8[i] ^ m2[i] ^ a[i];
      md[i] = m8[i] ^ m4[i] ^ a[i];
      me[i] = m8[i] ^ m4[i] ^ m2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign state_o[127 - 32*c -: 32] = inv_mix_col(state_i[127 - 32*c -: 32]);
  end

endmodule

`default_nettype wire

// File: rtl/aes_inv_sbox.sv
// +----------------------------------------------------------------------------+
// | aes_inv_sbox : 8-bit combinational AES inverse S-box ROM                    |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module aes_inv_sbox (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign byte_o = INV_SBOX[byte_i];

endmodule

`default_nettype wire

// File: rtl/aes_dec_round_iter.sv
// +----------------------------------------------------------------------------+
// | aes_dec_round_iter : iterative AES-128 inverse cipher, one round per clock  |
// | Optional build macro AES_DEC_ZEROIZE_EN clears plaintext after handoff.     |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module aes_dec_round_iter
  import aes_pkg::*;
#(
  parameter int NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam logic [3:0] LAST_KEY = 4'(NR);

  state_t       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] s_q, s_d;

  logic [127:0] w_isr;
  logic [127:0] w_isb;
  logic [127:0] w_ark;
  logic [127:0] w_imc;

  assign w_isr = inv_shift_rows(s_q);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .byte_i (w_isr[127 - 8*i -: 8]),
      .byte_o (w_isb[127 - 8*i -: 8])
    );
  end

  assign w_ark = w_isb ^ rk_data;

  aes_inv_mix_columns u_imc (
    .state_i (w_ark),
    .state_o (w_imc)
  );

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    s_d     = s_q;
    rk_idx  = LAST_KEY;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          s_d     = in_data ^ rk_data;
          rnd_d   = LAST_KEY - 4'd1;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        rk_idx = rnd_q;
        s_d    = w_imc;
        if (rnd_q == 4'd1) begin
          rnd_d   = 4'd0;
          state_d = ST_FINAL;
        end else begin
          rnd_d = rnd_q - 4'd1;
        end
      end
      ST_FINAL: begin
        rk_idx  = 4'd0;
        s_d     = w_ark;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
`ifdef AES_DEC_ZEROIZE_EN
          s_d = '0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rnd_q   <= 4'd0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      s_q     <= s_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_ROUND) || (state_q == ST_FINAL);

`ifdef AES_DEC_ZEROIZE_EN
  assign out_data = out_valid ? s_q : '0;
`else
  assign out_data = s_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes_dec_round_iter.sv
// Directed and randomized checks of aes_dec_round_iter against FIPS-197 vectors
// and a GF(2^8)-derived reference model; key store is expanded inside the bench.
`timescale 1ns/1ps
`default_nettype none

module tb_aes_dec_round_iter;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];
  logic [127:0] sched [2][16];
  logic         key_sel;

  always #5 clk = ~clk;

  always_comb rk_data = sched[key_sel][rk_idx];

  aes_dec_round_iter #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); maps 0 to 0.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, sq;
    r = 8'h01; sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic build_tables();
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      b = ginv(8'(x));
      sb[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
    for (int s = 0; s < 2; s++) for (int r = 0; r < 16; r++) sched[s][r] = '0;
  endtask

  task automatic expand_key(input logic [127:0] key, input int slot);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) sched[slot][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] ref_dec(input logic [127:0] ct, input int slot);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [127:0] s;
    s = ct ^ sched[slot][10];
    for (int r = 9; r >= 0; r--) begin
      for (int i = 0; i < 16; i++) b[i] = s[127 - 8*i -: 8];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) t[4*c + rw] = isb[b[4*((c - rw + 4) % 4) + rw]];
      for (int i = 0; i < 16; i++) s[127 - 8*i -: 8] = t[i];
      s = s ^ sched[slot][r];
      if (r != 0) begin
        for (int i = 0; i < 16; i++) b[i] = s[127 - 8*i -: 8];
        for (int c = 0; c < 4; c++) begin
          t[4*c+0] = gmul(b[4*c],8'h0e) ^ gmul(b[4*c+1],8'h0b) ^ gmul(b[4*c+2],8'h0d) ^ gmul(b[4*c+3],8'h09);
          t[4*c+1] = gmul(b[4*c],8'h09) ^ gmul(b[4*c+1],8'h0e) ^ gmul(b[4*c+2],8'h0b) ^ gmul(b[4*c+3],8'h0d);
          t[4*c+2] = gmul(b[4*c],8'h0d) ^ gmul(b[4*c+1],8'h09) ^ gmul(b[4*c+2],8'h0e) ^ gmul(b[4*c+3],8'h0b);
          t[4*c+3] = gmul(b[4*c],8'h0b) ^ gmul(b[4*c+1],8'h0d) ^ gmul(b[4*c+2],8'h09) ^ gmul(b[4*c+3],8'h0e);
        end
        for (int i = 0; i < 16; i++) s[127 - 8*i -: 8] = t[i];
      end
    end
    return s;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; key_sel = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (rk_idx !== 4'd10) begin errors++; $display("FAIL reset_rk_idx got %0d want 10", rk_idx); end
    checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    rst = 1'b0;
  endtask

  task automatic test_decrypt();
    int busy_cnt;
    key_sel = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || rk_idx !== 4'd10) begin
      errors++; $display("FAIL t1_idle got ready=%b rk_idx=%0d want 1/10", in_ready, rk_idx);
    end
    in_valid = 1'b1; in_data = C1; out_ready = 1'b1;
    busy_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      in_valid = 1'b0; in_data = '0;
      checks++; if (rk_idx !== 4'(10 - k) || out_valid !== 1'b0) begin
        errors++; $display("FAIL t1_round%0d got rk_idx=%0d valid=%b want %0d/0", k, rk_idx, out_valid, 10 - k);
      end
      if (busy === 1'b1) busy_cnt++;
`ifdef AES_DEC_ZEROIZE_EN
      checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL t1_zero_busy got %h want 0", out_data); end
`endif
    end
    checks++; if (busy_cnt != 10) begin errors++; $display("FAIL t1_busy_cycles got %0d want 10", busy_cnt); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL t1_done_flags got valid=%b busy=%b ready=%b want 1/0/0", out_valid, busy, in_ready);
    end
    checks++; if (out_data !== P1) begin errors++; $display("FAIL t1_plaintext got %h want %h", out_data, P1); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || rk_idx !== 4'd10) begin
      errors++; $display("FAIL t1_after_hs got valid=%b ready=%b rk_idx=%0d want 0/1/10", out_valid, in_ready, rk_idx);
    end
`ifdef AES_DEC_ZEROIZE_EN
    checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL t1_zero_idle got %h want 0", out_data); end
`else
    checks++; if (out_data !== P1) begin errors++; $display("FAIL t1_hold_idle got %h want %h", out_data, P1); end
`endif
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    key_sel = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_data = C2; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 20 && out_valid !== 1'b1; k++) @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t2_timeout got valid=%b want 1", out_valid); end
    for (int k = 0; k <= 5; k++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== P2 || in_ready !== 1'b0) begin
        errors++; $display("FAIL t2_stall%0d got valid=%b ready=%b data=%h want 1/0/%h", k, out_valid, in_ready, out_data, P2);
      end
      if (k < 5) begin in_valid = 1'b1; in_data = C1; end
      else begin in_valid = 1'b0; out_ready = 1'b1; end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL t2_after_hs got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    out_ready = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL t2_stray_accept got busy=%b ready=%b want 0/1", busy, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    key_sel = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = C1; out_ready = 1'b1;
    @(negedge clk);
    in_data = C2;
    lat = 1;
    for (int k = 0; k < 20 && out_valid !== 1'b1; k++) begin @(negedge clk); lat++; end
    checks++; if (lat != 11 || out_data !== P1) begin
      errors++; $display("FAIL t3_first got lat=%0d data=%h want 11/%h", lat, out_data, P1);
    end
    key_sel = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL t3_gap got ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || rk_idx !== 4'd9) begin
      errors++; $display("FAIL t3_second_accept got busy=%b rk_idx=%0d want 1/9", busy, rk_idx);
    end
    lat = 1;
    for (int k = 0; k < 20 && out_valid !== 1'b1; k++) begin @(negedge clk); lat++; end
    checks++; if (lat != 11 || out_data !== P2) begin
      errors++; $display("FAIL t3_second got lat=%0d data=%h want 11/%h", lat, out_data, P2);
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL t3_end got ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    key_sel = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = C1; out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin @(negedge clk); in_valid = 1'b0; end
    checks++; if (rk_idx !== 4'd5 || busy !== 1'b1) begin
      errors++; $display("FAIL t4_mid got rk_idx=%0d busy=%b want 5/1", rk_idx, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || rk_idx !== 4'd10 || out_data !== 128'h0) begin
      errors++; $display("FAIL t4_reset got ready=%b valid=%b busy=%b rk_idx=%0d data=%h want 1/0/0/10/0",
                         in_ready, out_valid, busy, rk_idx, out_data);
    end
    rst = 1'b0; out_ready = 1'b0;
    test_decrypt();
  endtask

  task automatic test_random();
    logic [127:0] key, ct, exp;
    bit seen, done;
    key_sel = 1'b0;
    for (int n = 0; n < 40; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      ct  = {$urandom, $urandom, $urandom, $urandom};
      expand_key(key, 0);
      exp = ref_dec(ct, 0);
      @(negedge clk);
      in_valid = 1'b1; in_data = ct; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      seen = 1'b0; done = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
        @(negedge clk);
        if (seen) begin
          checks++; if (out_valid !== 1'b1) begin
            errors++; done = 1'b1; $display("FAIL t6_valid_drop blk=%0d got %b want 1", n, out_valid);
          end
        end
        if (out_valid === 1'b1) begin
          seen = 1'b1;
          checks++; if (out_data !== exp) begin
            errors++; $display("FAIL t6_data blk=%0d got %h want %h", n, out_data, exp);
          end
        end
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid === 1'b1 && out_ready) done = 1'b1;
      end
      checks++; if (!done) begin errors++; $display("FAIL t6_timeout blk=%0d got no handshake want handshake", n); end
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    build_tables();
    expand_key(K1, 0);
    expand_key(K2, 1);
    test_reset();
    test_decrypt();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
